// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states,
// ALU control codes, instruction-class opcodes and data-processing commands.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef logic [1:0] alu_ctl_t;

    localparam alu_ctl_t ALU_ADD = 2'b00;
    localparam alu_ctl_t ALU_SUB = 2'b01;
    localparam alu_ctl_t ALU_AND = 2'b10;
    localparam alu_ctl_t ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Commands whose result defines carry/overflow, so S also updates C and V.
    function automatic logic is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

    // Moore control bundle produced by the state decode.
    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode: maps the data-processing cmd and S bit to the
// ALU operation, the flag-write request and the CMP write suppression.
module alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [5:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_funct;

    assign cmd          = Funct[4:1];
    assign s_bit        = Funct[0];
    assign unused_funct = Funct[5];

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        if (ALUOp) begin
            case (cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: begin
                    ALUControl = ALU_SUB;
                    NoWrite    = 1'b1;
                end
                default: ALUControl = ALU_ADD;
            endcase
            FlagW[1] = s_bit;
            FlagW[0] = s_bit & is_arith(cmd);
        end
    end

endmodule

// File: rtl/multicycle_decoder.sv
// Control FSM for the multicycle ARM core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects plus raw write requests.
module multicycle_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [1:0] flagw_raw;
    logic       nowrite_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.nextpc    = 1'b1;
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
            end
            DECODE: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
            end
            MEMADR: begin
                ctrl.alusrcb = 2'b01;
            end
            MEMREAD: begin
                ctrl.adrsrc = 1'b1;
            end
            MEMWB: begin
                ctrl.resultsrc = 2'b01;
                ctrl.regw      = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = 1'b1;
            end
            EXECUTER: begin
                ctrl.aluop = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = 1'b1;
            end
            ALUWB: begin
                ctrl.regw = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrcb   = 2'b01;
                ctrl.resultsrc = 2'b10;
                ctrl.branch    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (ctrl.aluop),
        .Funct      (Funct),
        .ALUControl (ALUControl),
        .FlagW      (flagw_raw),
        .NoWrite    (nowrite_raw)
    );

    // Write-type outputs are gated by reset directly so an aborted
    // instruction cannot leak a write before the state register settles.
    assign IRWrite = ctrl.irwrite & reset;
    assign NextPC  = ctrl.nextpc & reset;
    assign RegW    = ctrl.regw & reset;
    assign MemW    = ctrl.memw & reset;
    assign FlagW   = flagw_raw & {2{reset}};
    assign NoWrite = nowrite_raw & reset;
    assign PCS     = (ctrl.branch | (ctrl.regw & (Rd == 4'hF))) & reset;

    assign AdrSrc    = ctrl.adrsrc;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;

    assign ImmSrc    = Op;
    assign RegSrc[0] = (Op == OP_BR);
    assign RegSrc[1] = (Op == OP_MEM);
    assign State     = state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Bench for multicycle_decoder: per-instruction expected traces built from
// instruction class, compared cycle by cycle against every output.
module tb_multicycle_decoder;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, NoWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, npc, regw, memw, pcs, nowr, adr, srca;
        logic [1:0] res, srcb, aluc, flagw, imm, rsrc;
    } exp_t;

    logic [23:0] exp_q[$];

    multicycle_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    always #5 clk = ~clk;

    // Table-style ALU semantics: {ALUControl, FlagW, NoWrite}.
    function automatic logic [4:0] alu_ref(input logic [5:0] f);
        logic [3:0] cmd;
        logic       s;
        logic [1:0] op;
        logic       arith;
        logic       nw;
        cmd = f[4:1];
        s   = f[0];
        nw  = 1'b0;
        arith = 1'b0;
        if (cmd == 4'b0100)      begin op = 2'b00; arith = 1'b1; end
        else if (cmd == 4'b0010) begin op = 2'b01; arith = 1'b1; end
        else if (cmd == 4'b0000) begin op = 2'b10; end
        else if (cmd == 4'b1100) begin op = 2'b11; end
        else if (cmd == 4'b1010) begin op = 2'b01; arith = 1'b1; nw = 1'b1; end
        else                     begin op = 2'b00; end
        return {op, s, s & arith, nw};
    endfunction

    function automatic exp_t base(input logic [1:0] op);
        exp_t r;
        r = '0;
        r.imm  = op;
        r.rsrc = {op == 2'b01, op == 2'b10};
        return r;
    endfunction

    function automatic void build_trace(input logic [1:0] op, input logic [5:0] f,
                                        input logic [3:0] rd);
        exp_t r;
        r = base(op); r.st = FETCH; r.irw = 1; r.npc = 1; r.srca = 1;
        r.srcb = 2'b10; r.res = 2'b10; exp_q.push_back(r);
        r = base(op); r.st = DECODE; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10;
        exp_q.push_back(r);
        if (op == 2'b00) begin
            r = base(op);
            r.st = f[5] ? EXECUTEI : EXECUTER;
            r.srcb = f[5] ? 2'b01 : 2'b00;
            {r.aluc, r.flagw, r.nowr} = alu_ref(f);
            exp_q.push_back(r);
            r = base(op); r.st = ALUWB; r.regw = 1; r.pcs = (rd == 4'd15);
            exp_q.push_back(r);
        end else if (op == 2'b01) begin
            r = base(op); r.st = MEMADR; r.srcb = 2'b01; exp_q.push_back(r);
            if (f[0]) begin
                r = base(op); r.st = MEMREAD; r.adr = 1; exp_q.push_back(r);
                r = base(op); r.st = MEMWB; r.res = 2'b01; r.regw = 1;
                r.pcs = (rd == 4'd15); exp_q.push_back(r);
            end else begin
                r = base(op); r.st = MEMWRITE; r.adr = 1; r.memw = 1;
                exp_q.push_back(r);
            end
        end else if (op == 2'b10) begin
            r = base(op); r.st = BRANCH; r.srcb = 2'b01; r.res = 2'b10; r.pcs = 1;
            exp_q.push_back(r);
        end
    endfunction

    // Called with State=FETCH before the next rising edge; returns likewise.
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd);
        logic [23:0] e;
        logic [23:0] obs;
        int          cyc;
        build_trace(op, f, rd);
        Op = op; Funct = f; Rd = rd;
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e   = exp_q.pop_front();
            obs = {State, IRWrite, NextPC, RegW, MemW, PCS, NoWrite, AdrSrc, ALUSrcA,
                   ResultSrc, ALUSrcB, ALUControl, FlagW, ImmSrc, RegSrc};
            n_total++;
            if (obs !== e)
                $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, obs, e);
            else
                n_pass++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        reset = 1'b0; Op = 2'b00; Funct = '0; Rd = '0;
        repeat (3) @(negedge clk);
        #1;
        obs = {State, IRWrite, NextPC, RegW, MemW, PCS, ALUSrcA, ALUSrcB, ResultSrc};
        n_total++;
        if (obs !== {4'd0, 5'b00000, 1'b1, 2'b10, 2'b10})
            $display("FAIL reset_hold: got %h expected %h", obs,
                     {4'd0, 5'b00000, 1'b1, 2'b10, 2'b10});
        else
            n_pass++;
        n_total++;
        if (FlagW !== 2'b00 || NoWrite !== 1'b0)
            $display("FAIL reset_flags: got %b%b expected 000", FlagW, NoWrite);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if ({IRWrite, NextPC, State} !== {2'b11, 4'd0})
            $display("FAIL reset_release: got %b%b st%0d expected 11 st0",
                     IRWrite, NextPC, State);
        else
            n_pass++;
    endtask

    task automatic test_reset_midway();
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({State, MemW} !== {4'd5, 1'b1})
            $display("FAIL mid_pre: got st%0d memw%b expected st5 memw1", State, MemW);
        else
            n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({State, MemW, RegW, PCS} !== {4'd0, 3'b000})
            $display("FAIL mid_abort: got st%0d w%b%b%b expected st0 w000",
                     State, MemW, RegW, PCS);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        run_instr("adds_r1", 2'b00, 6'b001001, 4'd1);
        run_instr("adds_imm", 2'b00, 6'b101001, 4'd1);
        run_instr("cmp", 2'b00, 6'b010101, 4'd0);
        run_instr("orr", 2'b00, 6'b011000, 4'd2);
        run_instr("and_pc", 2'b00, 6'b100001, 4'd15);
        run_instr("ldr_pc", 2'b01, 6'b011001, 4'd15);
        run_instr("ldr_r4", 2'b01, 6'b011001, 4'd4);
        run_instr("str", 2'b01, 6'b011000, 4'd5);
        run_instr("b", 2'b10, 6'b100000, 4'd0);
        run_instr("undef", 2'b11, 6'b111111, 4'd15);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr("random", op, f, rd);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midway();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
